rf_op_ctrl: RTL and testbench

RF_OP_CTRL -- requirements
Module: rf_op_ctrl

---
 rtl/rf_op_pkg.sv | 27 ++
 rtl/rf_op_alu.sv | 38 +++
 rtl/rf_op_ctrl.sv | 130 +++++++++++++
 tb/tb_rf_op_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_op_pkg.sv
// Shared constants for the register-file operation controller: default widths,
// operation codes and FSM state encodings, used by the RTL and its bench.
package rf_op_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READ  = 2'b01;
    localparam logic [1:0] ST_EXEC  = 2'b10;
    localparam logic [1:0] ST_WRITE = 2'b11;

    function automatic string op_name(input logic [1:0] op);
        case (op)
            OP_ADD:  return "ADD";
            OP_SUB:  return "SUB";
            OP_AND:  return "AND";
            default: return "XOR";
        endcase
    endfunction

endpackage

// File: rtl/rf_op_alu.sv
// Purely combinational ALU: ADD/SUB with carry/borrow, bitwise AND/XOR.
module rf_op_alu
    import rf_op_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] diff_w;

    assign sum_w  = {1'b0, a} + {1'b0, b};
    // The extra top bit of the widened difference is set exactly when a < b.
    assign diff_w = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum_w[DATA_W-1:0];
                carry  = sum_w[DATA_W];
            end
            OP_SUB: begin
                result = diff_w[DATA_W-1:0];
                carry  = diff_w[DATA_W];
            end
            OP_AND:  result = a & b;
            default: result = a ^ b;
        endcase
    end

endmodule

// File: rtl/rf_op_ctrl.sv
// Sequences one register-file operation per command: IDLE -> READ -> EXEC -> WRITE.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
module rf_op_ctrl
    import rf_op_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic [ADDR_W-1:0] rf_rd_addr_a,
    output logic [ADDR_W-1:0] rf_rd_addr_b,
    input  logic [DATA_W-1:0] rf_d_out_a,
    input  logic [DATA_W-1:0] rf_d_out_b,
    output logic              rf_wr,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_d_in,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic [1:0]        dbg_state
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] src_a_q, src_a_d;
    logic [ADDR_W-1:0] src_b_q, src_b_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              wr_active;

    rf_op_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (opa_q),
        .b      (opb_q),
        .op     (op_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_d    = dst_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    src_a_d = cmd_src_a;
                    src_b_d = cmd_src_b;
                    dst_d   = cmd_dst;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                opa_d   = rf_d_out_a;
                opb_d   = rf_d_out_b;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_result;
                carry_d  = alu_carry;
                zero_d   = (alu_result == '0);
                state_d  = ST_WRITE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_q    <= dst_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    // Reset gates the write strobe directly so a WRITE cycle under reset is harmless.
    assign wr_active    = (state_q == ST_WRITE) && !reset;
    assign rf_wr        = wr_active;
    assign done         = wr_active;
    assign rf_wr_addr   = wr_active ? dst_q : '0;
    assign rf_d_in      = wr_active ? result_q : '0;
    assign cmd_ready    = (state_q == ST_IDLE) && !reset;
    assign rf_rd_addr_a = src_a_q;
    assign rf_rd_addr_b = src_b_q;
    assign result       = result_q;
    assign carry        = carry_q;
    assign zero         = zero_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rf_op_ctrl.sv
// Bench for rf_op_ctrl: 8x16 register-file model, directed scenarios and a
// randomized command stream checked against an array-based reference model.
module tb_rf_op_ctrl;
    import rf_op_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int AW = ADDR_W_DEF;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_src_a, cmd_src_b, cmd_dst;
    logic [AW-1:0] rf_rd_addr_a, rf_rd_addr_b;
    logic [DW-1:0] rf_d_out_a, rf_d_out_b;
    logic          rf_wr;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_d_in;
    logic          done;
    logic [DW-1:0] result;
    logic          carry, zero;
    logic [1:0]    dbg_state;

    logic          tb_wr_en;
    logic [AW-1:0] tb_wr_addr;
    logic [DW-1:0] tb_wr_data;

    logic [DW-1:0] rf_mem [8];
    logic [DW-1:0] ref_rf [8];

    int checks = 0;
    int errors = 0;

    rf_op_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_src_a    (cmd_src_a),
        .cmd_src_b    (cmd_src_b),
        .cmd_dst      (cmd_dst),
        .rf_rd_addr_a (rf_rd_addr_a),
        .rf_rd_addr_b (rf_rd_addr_b),
        .rf_d_out_a   (rf_d_out_a),
        .rf_d_out_b   (rf_d_out_b),
        .rf_wr        (rf_wr),
        .rf_wr_addr   (rf_wr_addr),
        .rf_d_in      (rf_d_in),
        .done         (done),
        .result       (result),
        .carry        (carry),
        .zero         (zero),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_d_out_a = rf_mem[rf_rd_addr_a];
    assign rf_d_out_b = rf_mem[rf_rd_addr_b];

    always @(posedge clk) begin
        if (rf_wr) rf_mem[rf_wr_addr] <= rf_d_in;
        else if (tb_wr_en) rf_mem[tb_wr_addr] <= tb_wr_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input logic [AW-1:0] a, input logic [DW-1:0] v);
        tb_wr_en = 1'b1;
        tb_wr_addr = a;
        tb_wr_data = v;
        step();
        tb_wr_en = 1'b0;
        ref_rf[a] = v;
    endtask

    // Reference semantics from the operation definitions, with plain integer arithmetic.
    function automatic void ref_exec(input logic [1:0] op, input logic [DW-1:0] a, b,
                                     output logic [DW-1:0] r, output logic c);
        int s;
        case (op)
            OP_ADD: begin
                s = int'(a) + int'(b);
                r = s[DW-1:0];
                c = (s >= (1 << DW));
            end
            OP_SUB: begin
                r = a - b;
                c = (a < b);
            end
            OP_AND: begin
                r = a & b;
                c = 1'b0;
            end
            default: begin
                r = a ^ b;
                c = 1'b0;
            end
        endcase
    endfunction

    // Issues one command at the first cmd_ready and observes cycles N+1..N+4.
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] sa, sb, d,
                           input bit hold_junk,
                           output int wr_cyc, output int n_wr, output int n_done,
                           output logic [AW-1:0] w_addr, output logic [DW-1:0] w_data,
                           output logic [DW-1:0] w_res, output logic w_c, output logic w_z,
                           output logic [AW-1:0] rd_a, output logic [AW-1:0] rd_b,
                           output logic rdy_after);
        int waited = 0;
        wr_cyc = -1; n_wr = 0; n_done = 0;
        w_addr = '0; w_data = '0; w_res = '0; w_c = 1'b0; w_z = 1'b0;
        rd_a = '0; rd_b = '0; rdy_after = 1'b0;
        while (!cmd_ready && waited < 10) begin
            step();
            waited++;
        end
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d;
        step();
        for (int c = 1; c <= 4; c++) begin
            if (hold_junk && c < 4) begin
                cmd_valid = 1'b1;
                cmd_op = 2'($urandom_range(0, 3));
                cmd_src_a = AW'($urandom_range(0, 7));
                cmd_src_b = AW'($urandom_range(0, 7));
                cmd_dst = AW'($urandom_range(0, 7));
            end else begin
                cmd_valid = 1'b0;
            end
            if (c == 1) begin
                rd_a = rf_rd_addr_a;
                rd_b = rf_rd_addr_b;
            end
            if (done) n_done++;
            if (rf_wr) begin
                n_wr++;
                wr_cyc = c;
                w_addr = rf_wr_addr;
                w_data = rf_d_in;
                w_res = result;
                w_c = carry;
                w_z = zero;
            end
            if (c == 4) rdy_after = cmd_ready;
            else step();
        end
        cmd_valid = 1'b0;
    endtask

    int wc, nw, nd;
    logic [AW-1:0] wa, ra, rb;
    logic [DW-1:0] wd, wr_res;
    logic wcar, wzer, rdy;

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cmd_ready); end
        checks++;
        if (rf_wr !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_wr got wr=%b done=%b exp 0", rf_wr, done); end
        reset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", cmd_ready); end
        checks++;
        if (result !== '0 || carry !== 1'b0 || zero !== 1'b0) begin
            errors++; $display("FAIL reset_flags got res=%h c=%b z=%b exp 0", result, carry, zero);
        end
        checks++;
        if (rf_rd_addr_a !== '0 || rf_rd_addr_b !== '0) begin
            errors++; $display("FAIL reset_rdaddr got %0d/%0d exp 0/0", rf_rd_addr_a, rf_rd_addr_b);
        end
    endtask

    task automatic test_add_basic();
        set_reg(3'd1, 16'h0005);
        set_reg(3'd2, 16'h0003);
        set_reg(3'd3, 16'h1234);
        run_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, wc, nw, nd, wa, wd, wr_res, wcar, wzer, ra, rb, rdy);
        checks++;
        if (wc !== 3 || nw !== 1) begin errors++; $display("FAIL add_latency got cycle=%0d writes=%0d exp 3/1", wc, nw); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL add_done got %0d pulses exp 1", nd); end
        checks++;
        if (wa !== 3'd3 || wd !== 16'h0008) begin errors++; $display("FAIL add_write got addr=%0d data=%h exp 3/0008", wa, wd); end
        checks++;
        if (wcar !== 1'b0 || wzer !== 1'b0 || wr_res !== 16'h0008) begin
            errors++; $display("FAIL add_flags got res=%h c=%b z=%b exp 0008/0/0", wr_res, wcar, wzer);
        end
        checks++;
        if (ra !== 3'd1 || rb !== 3'd2) begin errors++; $display("FAIL add_rdaddr got %0d/%0d exp 1/2", ra, rb); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL add_ready_n4 got %b exp 1", rdy); end
        checks++;
        if (rf_mem[3] !== 16'h0008) begin errors++; $display("FAIL add_r3 got %h exp 0008", rf_mem[3]); end
        checks++;
        if (rf_rd_addr_a !== 3'd1 || rf_rd_addr_b !== 3'd2) begin
            errors++; $display("FAIL add_rdaddr_hold got %0d/%0d exp 1/2", rf_rd_addr_a, rf_rd_addr_b);
        end
        ref_rf[3] = 16'h0008;
    endtask

    task automatic test_carry_sub();
        set_reg(3'd1, 16'hFFFF);
        set_reg(3'd2, 16'h0003);
        run_cmd(OP_ADD, 3'd1, 3'd1, 3'd4, 1'b0, wc, nw, nd, wa, wd, wr_res, wcar, wzer, ra, rb, rdy);
        checks++;
        if (wd !== 16'hFFFE || wcar !== 1'b1 || wzer !== 1'b0 || wa !== 3'd4) begin
            errors++; $display("FAIL add_carry got addr=%0d data=%h c=%b z=%b exp 4/FFFE/1/0", wa, wd, wcar, wzer);
        end
        run_cmd(OP_SUB, 3'd2, 3'd2, 3'd5, 1'b0, wc, nw, nd, wa, wd, wr_res, wcar, wzer, ra, rb, rdy);
        checks++;
        if (wd !== 16'h0000 || wcar !== 1'b0 || wzer !== 1'b1 || wa !== 3'd5) begin
            errors++; $display("FAIL sub_zero got addr=%0d data=%h c=%b z=%b exp 5/0000/0/1", wa, wd, wcar, wzer);
        end
        run_cmd(OP_SUB, 3'd2, 3'd1, 3'd6, 1'b0, wc, nw, nd, wa, wd, wr_res, wcar, wzer, ra, rb, rdy);
        checks++;
        if (wd !== 16'h0004 || wcar !== 1'b1 || wzer !== 1'b0 || wa !== 3'd6) begin
            errors++; $display("FAIL sub_borrow got addr=%0d data=%h c=%b z=%b exp 6/0004/1/0", wa, wd, wcar, wzer);
        end
        checks++;
        if (rf_mem[4] !== 16'hFFFE || rf_mem[5] !== 16'h0000 || rf_mem[6] !== 16'h0004) begin
            errors++; $display("FAIL carry_sub_regs got %h %h %h exp FFFE 0000 0004", rf_mem[4], rf_mem[5], rf_mem[6]);
        end
        ref_rf[4] = 16'hFFFE; ref_rf[5] = 16'h0000; ref_rf[6] = 16'h0004;
    endtask

    task automatic test_back_to_back();
        set_reg(3'd1, 16'h0005);
        set_reg(3'd2, 16'h0003);
        run_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b0, wc, nw, nd, wa, wd, wr_res, wcar, wzer, ra, rb, rdy);
        run_cmd(OP_XOR, 3'd3, 3'd2, 3'd7, 1'b0, wc, nw, nd, wa, wd, wr_res, wcar, wzer, ra, rb, rdy);
        checks++;
        if (wd !== 16'h000B || wa !== 3'd7 || wcar !== 1'b0) begin
            errors++; $display("FAIL dep_xor got addr=%0d data=%h c=%b exp 7/000B/0", wa, wd, wcar);
        end
        checks++;
        if (rf_mem[7] !== 16'h000B) begin errors++; $display("FAIL dep_r7 got %h exp 000B", rf_mem[7]); end
        ref_rf[3] = 16'h0008; ref_rf[7] = 16'h000B;
    endtask

    task automatic test_ignore_busy();
        logic [DW-1:0] exp_r;
        logic exp_c;
        ref_exec(OP_AND, ref_rf[1], ref_rf[2], exp_r, exp_c);
        run_cmd(OP_AND, 3'd1, 3'd2, 3'd0, 1'b1, wc, nw, nd, wa, wd, wr_res, wcar, wzer, ra, rb, rdy);
        checks++;
        if (nw !== 1 || wa !== 3'd0 || wd !== exp_r) begin
            errors++; $display("FAIL busy_single got writes=%0d addr=%0d data=%h exp 1/0/%h", nw, wa, wd, exp_r);
        end
        ref_rf[0] = exp_r;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (rf_wr !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL busy_extra_write cycle %0d got wr=%b done=%b exp 0", k, rf_wr, done);
            end
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (rf_mem[r] !== ref_rf[r]) begin errors++; $display("FAIL busy_reg R%0d got %h exp %h", r, rf_mem[r], ref_rf[r]); end
        end
    endtask

    task automatic test_reset_in_write();
        set_reg(3'd5, 16'hAAAA);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd5;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        checks++;
        if (rf_wr !== 1'b1) begin errors++; $display("FAIL rstw_reach_write got wr=%b exp 1", rf_wr); end
        reset = 1'b1;
        #1;
        checks++;
        if (rf_wr !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL rstw_gated got wr=%b done=%b ready=%b exp 0/0/0", rf_wr, done, cmd_ready);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstw_ready got %b exp 1", cmd_ready); end
        checks++;
        if (rf_mem[5] !== 16'hAAAA) begin errors++; $display("FAIL rstw_dst got %h exp AAAA", rf_mem[5]); end
    endtask

    task automatic test_reset_mid();
        int n_bad;
        for (int stage = 1; stage <= 2; stage++) begin
            set_reg(3'd6, 16'h5A5A);
            cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd6;
            step();
            cmd_valid = 1'b0;
            if (stage == 2) step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            n_bad = 0;
            for (int k = 0; k < 5; k++) begin
                if (rf_wr || done) n_bad++;
                step();
            end
            checks++;
            if (n_bad !== 0) begin errors++; $display("FAIL rst_mid stage %0d got %0d writes/done exp 0", stage, n_bad); end
            checks++;
            if (rf_mem[6] !== 16'h5A5A) begin errors++; $display("FAIL rst_mid_dst stage %0d got %h exp 5A5A", stage, rf_mem[6]); end
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [AW-1:0] sa, sb, d;
        logic [DW-1:0] exp_r;
        logic exp_c;
        for (int r = 0; r < 8; r++) set_reg(AW'(r), DW'($urandom));
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0: set_reg(AW'($urandom_range(0, 7)), 16'hFFFF);
                    1: set_reg(AW'($urandom_range(0, 7)), 16'h0000);
                    default: set_reg(AW'($urandom_range(0, 7)), DW'($urandom));
                endcase
            end
            op = 2'($urandom_range(0, 3));
            sa = AW'($urandom_range(0, 7));
            sb = ($urandom_range(0, 5) == 0) ? sa : AW'($urandom_range(0, 7));
            d = AW'($urandom_range(0, 7));
            ref_exec(op, ref_rf[sa], ref_rf[sb], exp_r, exp_c);
            run_cmd(op, sa, sb, d, ($urandom_range(0, 3) == 0), wc, nw, nd, wa, wd, wr_res, wcar, wzer, ra, rb, rdy);
            checks++;
            if (wc !== 3 || nw !== 1 || nd !== 1 || rdy !== 1'b1) begin
                errors++; $display("FAIL rnd_timing #%0d got cycle=%0d writes=%0d done=%0d ready=%b exp 3/1/1/1", n, wc, nw, nd, rdy);
            end
            checks++;
            if (wa !== d || wd !== exp_r || wr_res !== exp_r) begin
                errors++; $display("FAIL rnd_data #%0d %s R%0d,R%0d got addr=%0d data=%h exp %0d/%h",
                                   n, op_name(op), sa, sb, wa, wd, d, exp_r);
            end
            checks++;
            if (wcar !== exp_c || wzer !== (exp_r == '0)) begin
                errors++; $display("FAIL rnd_flags #%0d %s got c=%b z=%b exp %b/%b", n, op_name(op), wcar, wzer, exp_c, (exp_r == '0));
            end
            ref_rf[d] = exp_r;
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (rf_mem[r] !== ref_rf[r]) begin errors++; $display("FAIL rnd_reg R%0d got %h exp %h", r, rf_mem[r], ref_rf[r]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
        tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
        for (int r = 0; r < 8; r++) begin
            rf_mem[r] = '0;
            ref_rf[r] = '0;
        end
        #1;
        test_reset();
        test_add_basic();
        test_carry_sub();
        test_back_to_back();
        test_ignore_busy();
        test_reset_in_write();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
